// File: rtl/idm_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states and requester ids.
package idm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/idm_arbiter_if.sv
// Requester and memory bus of the idm_arbiter; the arbiter attaches through the slave modport.
interface idm_arbiter_if
  import idm_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // Handshake: a requester raises req with addr/we/wdata and holds them stable until
  // its done pulses for one cycle; there is no separate ready, the arbiter latches the
  // winner's fields on the grant edge and ignores requester inputs until DONE.
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_done;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_we;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_done;

  logic [DATA_W-1:0] rdata;
  logic              busy;
  state_t            state;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output dma_req, dma_addr, dma_we, dma_wdata,
    output mem_rdata,
    input  cpu_done, dma_done, rdata, busy, state,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  dma_req, dma_addr, dma_we, dma_wdata,
    input  mem_rdata,
    output cpu_done, dma_done, rdata, busy, state,
    output mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/idm_arb_pick.sv
// Combinational winner selection. IDM_ARB_RR_EN: round-robin on a tie; otherwise CPU has fixed priority.
module idm_arb_pick
  import idm_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
`ifdef IDM_ARB_RR_EN
  input  logic last,
`endif
  output logic winner
);

  always_comb begin
    winner = ID_CPU;
`ifdef IDM_ARB_RR_EN
    // On a tie the requester that did not win last time gets the slot.
    if (cpu_req && dma_req) begin
      winner = (last == ID_CPU) ? ID_DMA : ID_CPU;
    end else if (dma_req) begin
      winner = ID_DMA;
    end
`else
    if (dma_req && !cpu_req) begin
      winner = ID_DMA;
    end
`endif
  end

endmodule

// File: rtl/idm_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a shared instruction/data memory with fixed access latency.
// Build macro IDM_ARB_RR_EN switches the tie policy from CPU-priority to round-robin.
module idm_arbiter
  import idm_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LAT    = 1
) (
  input logic         clk,
  input logic         rst,
  idm_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              id_l;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata_l;
  logic              mem_we_l;
  logic              cpu_done_l;
  logic              dma_done_l;
  logic              winner;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef IDM_ARB_RR_EN
  logic last_grant;

  idm_arb_pick u_pick (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .last    (last_grant),
    .winner  (winner)
  );
`else
  idm_arb_pick u_pick (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .winner  (winner)
  );
`endif

  assign sel_we    = (winner == ID_DMA) ? bus.dma_we    : bus.cpu_we;
  assign sel_addr  = (winner == ID_DMA) ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = (winner == ID_DMA) ? bus.dma_wdata : bus.cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      id_l       <= ID_CPU;
      we_l       <= 1'b0;
      addr_l     <= '0;
      wdata_l    <= '0;
      rdata_l    <= '0;
      mem_we_l   <= 1'b0;
      cpu_done_l <= 1'b0;
      dma_done_l <= 1'b0;
`ifdef IDM_ARB_RR_EN
      last_grant <= ID_DMA;
`endif
    end else begin
      mem_we_l   <= 1'b0;
      cpu_done_l <= 1'b0;
      dma_done_l <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            state    <= ACCESS;
            cnt      <= CNT_LOAD;
            id_l     <= winner;
            we_l     <= sel_we;
            addr_l   <= sel_addr;
            wdata_l  <= sel_wdata;
            // Write strobe covers only the first access cycle.
            mem_we_l <= sel_we;
`ifdef IDM_ARB_RR_EN
            last_grant <= winner;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state      <= DONE;
            cpu_done_l <= (id_l == ID_CPU);
            dma_done_l <= (id_l == ID_DMA);
            if (!we_l) begin
              rdata_l <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.state     = state;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_addr  = addr_l;
  assign bus.mem_wdata = wdata_l;
  assign bus.mem_we    = mem_we_l;
  assign bus.rdata     = rdata_l;
  assign bus.cpu_done  = cpu_done_l;
  assign bus.dma_done  = dma_done_l;

endmodule

// File: tb/tb_idm_arbiter.sv
// Directed bench for idm_arbiter: three instances at LAT=1, 2 and 3 share one clock.
module tb_idm_arbiter;
  import idm_arb_pkg::*;

  logic clk;
  logic r1, r2, r3;
  int   errors;
  int   checks;

  idm_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
  idm_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b2 ();
  idm_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b3 ();

  idm_arbiter #(.ADDR_W(8), .DATA_W(8), .LAT(1)) u1 (.clk(clk), .rst(r1), .bus(b1));
  idm_arbiter #(.ADDR_W(8), .DATA_W(8), .LAT(2)) u2 (.clk(clk), .rst(r2), .bus(b2));
  idm_arbiter #(.ADDR_W(8), .DATA_W(8), .LAT(3)) u3 (.clk(clk), .rst(r3), .bus(b3));

  // Memory model: read data is a fixed function of the address.
  assign b1.mem_rdata = b1.mem_addr ^ 8'hB5;
  assign b2.mem_rdata = b2.mem_addr ^ 8'hB5;
  assign b3.mem_rdata = b3.mem_addr ^ 8'hB5;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b1.cpu_req = 0; b1.cpu_addr = 0; b1.cpu_we = 0; b1.cpu_wdata = 0;
    b1.dma_req = 0; b1.dma_addr = 0; b1.dma_we = 0; b1.dma_wdata = 0;
    b2.cpu_req = 0; b2.cpu_addr = 0; b2.cpu_we = 0; b2.cpu_wdata = 0;
    b2.dma_req = 0; b2.dma_addr = 0; b2.dma_we = 0; b2.dma_wdata = 0;
    b3.cpu_req = 0; b3.cpu_addr = 0; b3.cpu_we = 0; b3.cpu_wdata = 0;
    b3.dma_req = 0; b3.dma_addr = 0; b3.dma_we = 0; b3.dma_wdata = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    r1 = 1; r2 = 1; r3 = 1;
    step();
    step();
    checks++; if (b1.state !== IDLE) begin errors++; $display("FAIL reset_state1 got %0d exp %0d", b1.state, IDLE); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", b1.busy); end
    checks++; if (b1.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we1 got %b exp 0", b1.mem_we); end
    checks++; if ({b1.cpu_done, b1.dma_done} !== 2'b00) begin errors++; $display("FAIL reset_done1 got %b exp 00", {b1.cpu_done, b1.dma_done}); end
    checks++; if (b1.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata1 got %h exp 00", b1.rdata); end
    checks++; if (b1.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr1 got %h exp 00", b1.mem_addr); end
    checks++; if (b1.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata1 got %h exp 00", b1.mem_wdata); end
    checks++; if (b2.state !== IDLE) begin errors++; $display("FAIL reset_state2 got %0d exp %0d", b2.state, IDLE); end
    checks++; if (b3.state !== IDLE) begin errors++; $display("FAIL reset_state3 got %0d exp %0d", b3.state, IDLE); end
    r1 = 0; r2 = 0; r3 = 0;
    step();
    checks++; if (b1.state !== IDLE) begin errors++; $display("FAIL idle_no_req got %0d exp %0d", b1.state, IDLE); end
  endtask

  task automatic test_cpu_read();
    b1.cpu_req = 1; b1.cpu_addr = 8'h10; b1.cpu_we = 0;
    step();  // t+1
    checks++; if (b1.state !== ACCESS) begin errors++; $display("FAIL rd_access got %0d exp %0d", b1.state, ACCESS); end
    checks++; if (b1.mem_addr !== 8'h10) begin errors++; $display("FAIL rd_mem_addr got %h exp 10", b1.mem_addr); end
    checks++; if (b1.mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got %b exp 0", b1.mem_we); end
    checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", b1.busy); end
    checks++; if ({b1.cpu_done, b1.dma_done} !== 2'b00) begin errors++; $display("FAIL rd_early_done got %b exp 00", {b1.cpu_done, b1.dma_done}); end
    step();  // t+2
    checks++; if (b1.state !== DONE) begin errors++; $display("FAIL rd_done_state got %0d exp %0d", b1.state, DONE); end
    checks++; if (b1.cpu_done !== 1'b1) begin errors++; $display("FAIL rd_cpu_done got %b exp 1", b1.cpu_done); end
    checks++; if (b1.dma_done !== 1'b0) begin errors++; $display("FAIL rd_dma_done got %b exp 0", b1.dma_done); end
    checks++; if (b1.rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got %h exp a5", b1.rdata); end
    b1.cpu_req = 0;
    step();  // t+3
    checks++; if (b1.state !== IDLE) begin errors++; $display("FAIL rd_back_idle got %0d exp %0d", b1.state, IDLE); end
    checks++; if (b1.cpu_done !== 1'b0) begin errors++; $display("FAIL rd_done_one_cycle got %b exp 0", b1.cpu_done); end
    checks++; if (b1.rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata_hold got %h exp a5", b1.rdata); end
  endtask

  task automatic test_dma_write();
    int we_cycles;
    we_cycles = 0;
    b3.dma_req = 1; b3.dma_addr = 8'h20; b3.dma_wdata = 8'h3C; b3.dma_we = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (b3.mem_we === 1'b1) begin
        we_cycles++;
        checks++; if (b3.mem_addr !== 8'h20) begin errors++; $display("FAIL wr_mem_addr got %h exp 20", b3.mem_addr); end
        checks++; if (b3.mem_wdata !== 8'h3C) begin errors++; $display("FAIL wr_mem_wdata got %h exp 3c", b3.mem_wdata); end
      end
      checks++; if (b3.mem_we !== (k == 1)) begin errors++; $display("FAIL wr_mem_we cyc%0d got %b exp %b", k, b3.mem_we, (k == 1)); end
      checks++; if (b3.dma_done !== (k == 4)) begin errors++; $display("FAIL wr_dma_done cyc%0d got %b exp %b", k, b3.dma_done, (k == 4)); end
      checks++; if (b3.cpu_done !== 1'b0) begin errors++; $display("FAIL wr_cpu_done cyc%0d got %b exp 0", k, b3.cpu_done); end
      checks++; if (b3.state !== ((k == 4) ? DONE : ACCESS)) begin errors++; $display("FAIL wr_state cyc%0d got %0d", k, b3.state); end
    end
    checks++; if (we_cycles != 1) begin errors++; $display("FAIL wr_we_count got %0d exp 1", we_cycles); end
    checks++; if (b3.rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_unchanged got %h exp 00", b3.rdata); end
    b3.dma_req = 0; b3.dma_we = 0;
    step();
    checks++; if (b3.state !== IDLE) begin errors++; $display("FAIL wr_back_idle got %0d exp %0d", b3.state, IDLE); end
  endtask

  task automatic test_tie();
    int  n;
    logic exp_w;
    n = 0;
    r1 = 1;
    step();
    r1 = 0;
    b1.cpu_req = 1; b1.cpu_addr = 8'h11; b1.cpu_we = 0;
    b1.dma_req = 1; b1.dma_addr = 8'h22; b1.dma_we = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      checks++; if (b1.cpu_done && b1.dma_done) begin errors++; $display("FAIL tie_both_done cyc%0d got 11 exp one-hot", c); end
      if (b1.cpu_done || b1.dma_done) begin
`ifdef IDM_ARB_RR_EN
        exp_w = n[0];
`else
        exp_w = ID_CPU;
`endif
        checks++; if (b1.dma_done !== exp_w) begin errors++; $display("FAIL tie_winner grant%0d got dma_done=%b exp %b", n, b1.dma_done, exp_w); end
        checks++; if (b1.rdata !== (exp_w ? 8'h97 : 8'hA4)) begin errors++; $display("FAIL tie_rdata grant%0d got %h exp %h", n, b1.rdata, (exp_w ? 8'h97 : 8'hA4)); end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL tie_grant_count got %0d exp 4", n); end
    b1.cpu_req = 0; b1.dma_req = 0;
    step();
    step();
  endtask

  task automatic test_reset_abort();
    b3.cpu_req = 1; b3.cpu_addr = 8'h30; b3.cpu_wdata = 8'h5A; b3.cpu_we = 1;
    step();  // first ACCESS cycle
    checks++; if (b3.mem_we !== 1'b1) begin errors++; $display("FAIL abort_we_first got %b exp 1", b3.mem_we); end
    step();  // second ACCESS cycle
    checks++; if (b3.state !== ACCESS) begin errors++; $display("FAIL abort_access2 got %0d exp %0d", b3.state, ACCESS); end
    r3 = 1; b3.cpu_req = 0; b3.cpu_we = 0;
    step();
    checks++; if (b3.state !== IDLE) begin errors++; $display("FAIL abort_state got %0d exp %0d", b3.state, IDLE); end
    checks++; if (b3.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", b3.busy); end
    checks++; if (b3.mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we got %b exp 0", b3.mem_we); end
    checks++; if (b3.mem_addr !== 8'h00) begin errors++; $display("FAIL abort_mem_addr got %h exp 00", b3.mem_addr); end
    r3 = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (b3.cpu_done !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc%0d got %b exp 0", k, b3.cpu_done); end
      step();
    end
    checks++; if (b3.state !== IDLE) begin errors++; $display("FAIL abort_stays_idle got %0d exp %0d", b3.state, IDLE); end
  endtask

  task automatic test_drop_mid();
    b2.cpu_req = 1; b2.cpu_addr = 8'h40; b2.cpu_we = 0;
    step();  // t+1: granted, CPU drops, DMA starts pending
    checks++; if (b2.state !== ACCESS) begin errors++; $display("FAIL drop_access got %0d exp %0d", b2.state, ACCESS); end
    b2.cpu_req = 0; b2.cpu_addr = 8'hFF;
    b2.dma_req = 1; b2.dma_addr = 8'h50; b2.dma_we = 0;
    step();  // t+2
    checks++; if (b2.mem_addr !== 8'h40) begin errors++; $display("FAIL drop_addr_latched got %h exp 40", b2.mem_addr); end
    checks++; if (b2.cpu_done !== 1'b0) begin errors++; $display("FAIL drop_early_done got %b exp 0", b2.cpu_done); end
    step();  // t+3
    checks++; if (b2.cpu_done !== 1'b1) begin errors++; $display("FAIL drop_cpu_done got %b exp 1", b2.cpu_done); end
    checks++; if (b2.dma_done !== 1'b0) begin errors++; $display("FAIL drop_dma_done got %b exp 0", b2.dma_done); end
    checks++; if (b2.rdata !== 8'hF5) begin errors++; $display("FAIL drop_rdata got %h exp f5", b2.rdata); end
    step();  // t+4: IDLE, grant edge for DMA
    checks++; if (b2.state !== IDLE) begin errors++; $display("FAIL drop_idle_t4 got %0d exp %0d", b2.state, IDLE); end
    step();  // t+5
    checks++; if (b2.state !== ACCESS) begin errors++; $display("FAIL drop_dma_grant got %0d exp %0d", b2.state, ACCESS); end
    checks++; if (b2.mem_addr !== 8'h50) begin errors++; $display("FAIL drop_dma_addr got %h exp 50", b2.mem_addr); end
    step();
    step();  // t+7
    checks++; if (b2.dma_done !== 1'b1) begin errors++; $display("FAIL drop_dma_done2 got %b exp 1", b2.dma_done); end
    checks++; if (b2.rdata !== 8'hE5) begin errors++; $display("FAIL drop_dma_rdata got %h exp e5", b2.rdata); end
    b2.dma_req = 0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_tie();
    test_reset_abort();
    test_drop_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
